// File: rtl/ictrl_ibuffer_rd_sched.sv
// ----------------------------------------------------------------------------
// ictrl_ibuffer_rd_sched
//
// Streams a contiguous range of ibuffer lines to the NoC side. A command
// (base, len) is accepted while idle. The block then issues pipelined read
// requests into the arbiter's NoC read port and keeps at most MAX_OUTST reads
// in flight. Returned data is forwarded as a valid/ready stream with a last
// flag. A one-cycle done pulse follows the final delivered line.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready while idle)
//   cmd_base_addr       : first line address
//   cmd_len             : number of lines (0 completes with no reads)
//   busy                : a command is in progress
//   done                : registered one-cycle completion pulse
//   rd_cen/rd_ready     : read request handshake into the arbiter
//   rd_wen              : always 0 (read only)
//   rd_addr             : request address, wraps silently at 2^MEM_AW
//   rd_rvalid/rd_rready : read response handshake
//   rd_rdata            : read response data
//   out_valid/out_ready : output stream handshake
//   out_data, out_last  : output stream data and final-line flag
// ----------------------------------------------------------------------------
module ictrl_ibuffer_rd_sched #(
    parameter int DATA_WIDTH = 128,
    parameter int MEM_AW     = 15,
    parameter int LEN_W      = 16,
    parameter int MAX_OUTST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MEM_AW-1:0]     cmd_base_addr,
    input  logic [LEN_W-1:0]      cmd_len,
    output logic                  busy,
    output logic                  done,

    output logic                  rd_cen,
    output logic                  rd_wen,
    input  logic                  rd_ready,
    output logic [MEM_AW-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_rdata,
    input  logic                  rd_rvalid,
    output logic                  rd_rready,

    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam logic [OW-1:0]    OUTST_MAX = OW'(MAX_OUTST);
    localparam logic [OW-1:0]    OUTST_ONE = OW'(1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  iss_cnt_q, iss_cnt_d;
    logic [LEN_W-1:0]  rcv_cnt_q, rcv_cnt_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              done_q, done_d;

    logic              req_hs;
    logic              rsp_hs;

    // Request side is decoded from registered state only, so rd_cen and
    // rd_addr never depend combinationally on rd_ready and the address is
    // stable until the request is taken.
    assign busy      = (state_q != IDLE);
    assign cmd_ready = (state_q == IDLE);
    assign rd_wen    = 1'b0;
    assign rd_cen    = (state_q == ISSUE) && (iss_cnt_q < len_q) && (outst_q < OUTST_MAX);
    assign rd_addr   = (state_q == ISSUE) ? (base_q + MEM_AW'(iss_cnt_q)) : '0;

    // Response path is a straight wire-through while a command is active;
    // it is closed in IDLE so stray responses never leak downstream.
    assign out_valid = busy && rd_rvalid;
    assign out_data  = rd_rdata;
    assign rd_rready = busy && out_ready;
    assign out_last  = out_valid && (rcv_cnt_q == (len_q - LEN_ONE));
    assign done      = done_q;

    assign req_hs = rd_cen && rd_ready;
    assign rsp_hs = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        len_d     = len_q;
        iss_cnt_d = req_hs ? (iss_cnt_q + LEN_ONE) : iss_cnt_q;
        rcv_cnt_d = rsp_hs ? (rcv_cnt_q + LEN_ONE) : rcv_cnt_q;
        outst_d   = outst_q;
        done_d    = 1'b0;

        // A request and a response in the same cycle cancel out.
        case ({req_hs, rsp_hs})
            2'b10:   outst_d = outst_q + OUTST_ONE;
            2'b01:   outst_d = outst_q - OUTST_ONE;
            default: outst_d = outst_q;
        endcase

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    base_d    = cmd_base_addr;
                    len_d     = cmd_len;
                    iss_cnt_d = '0;
                    rcv_cnt_d = '0;
                    outst_d   = '0;
                    if (cmd_len != '0) begin
                        state_d = ISSUE;
                    end else begin
                        // Empty command: complete immediately, no reads.
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Responses cannot finish the command here: at most len-1
                // requests were accepted before the final request handshake.
                if (req_hs && (iss_cnt_d == len_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_hs && (rcv_cnt_d == len_q)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            len_q     <= '0;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
            outst_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            len_q     <= len_d;
            iss_cnt_q <= iss_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            outst_q   <= outst_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_ictrl_ibuffer_rd_sched.sv
// ----------------------------------------------------------------------------
// Testbench for ictrl_ibuffer_rd_sched. A small ibuffer model answers each
// accepted read after a programmable latency with data derived from the
// address. A table of command vectors is run through the scoreboard, followed
// by hand-written sequences for the outstanding limit, len=0 / busy command
// and reset in mid-command.
// ----------------------------------------------------------------------------
module tb_ictrl_ibuffer_rd_sched;

    localparam int DW = 128;
    localparam int AW = 15;
    localparam int LW = 16;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_addr;
    logic [LW-1:0] cmd_len;
    logic          busy;
    logic          done;
    logic          rd_cen;
    logic          rd_wen;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_rdata;
    logic          rd_rvalid;
    logic          rd_rready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_ready;

    always #5 clk = ~clk;

    ictrl_ibuffer_rd_sched #(
        .DATA_WIDTH(DW),
        .MEM_AW    (AW),
        .LEN_W     (LW),
        .MAX_OUTST (MO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base_addr(cmd_base_addr),
        .cmd_len      (cmd_len),
        .busy         (busy),
        .done         (done),
        .rd_cen       (rd_cen),
        .rd_wen       (rd_wen),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_rdata     (rd_rdata),
        .rd_rvalid    (rd_rvalid),
        .rd_rready    (rd_rready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready)
    );

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            lat;        // response latency in cycles
        int            omode;      // out_ready: 0 always, 1 toggle, 2 never
        int            rmode;      // rd_ready: 0 always, 1 random drops, 2 never
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        int            exp_beats;
        int            exp_span;   // last-first request cycle, -1 = not checked
    } vec_t;

    vec_t vecs[7];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [AW-1:0] pend_addr[$];
    int            pend_rdy[$];
    int            lat        = 1;
    int            omode      = 0;
    int            rmode      = 0;
    int            resp_allow = 1 << 20;

    logic          nxt_cv   = 1'b0;
    logic [AW-1:0] nxt_base = '0;
    logic [LW-1:0] nxt_len  = '0;

    logic [AW-1:0] exp_base = '0;
    int            exp_len  = 0;
    logic          exp_busy = 1'b0;
    int            n_iss    = 0;
    int            n_rcv    = 0;
    int            done_due = -1;
    int            done_cnt = 0;
    int            acc_cyc  = -1;
    int            last_done_cyc = -1;
    int            first_iss_cyc = 0;
    int            last_iss_cyc  = 0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr  = '0;
    logic          last_cen   = 1'b0;

    function automatic logic [DW-1:0] mkdata(input logic [AW-1:0] a);
        return {4{17'h1A5A5, a}};
    endfunction

    function automatic logic [AW-1:0] addr_at(input int k);
        logic [AW-1:0] t;
        t = exp_base + AW'(k);
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then check and
    // record what the next rising edge will do.
    task automatic step();
        logic exp_cen;
        logic exp_lst;
        @(negedge clk);
        cmd_valid     = nxt_cv;
        cmd_base_addr = nxt_base;
        cmd_len       = nxt_len;
        if (rmode == 0)      rd_ready = 1'b1;
        else if (rmode == 1) rd_ready = ($urandom_range(0, 2) != 0);
        else                 rd_ready = 1'b0;
        if (omode == 0)      out_ready = 1'b1;
        else if (omode == 1) out_ready = ((cyc % 2) == 0);
        else                 out_ready = 1'b0;
        if (resp_allow > 0 && pend_addr.size() > 0 && pend_rdy[0] <= cyc) begin
            rd_rvalid = 1'b1;
            rd_rdata  = mkdata(pend_addr[0]);
        end else begin
            rd_rvalid = 1'b0;
            rd_rdata  = '0;
        end
        #3;
        exp_cen = exp_busy && (n_iss < exp_len) && ((n_iss - n_rcv) < MO);
        exp_lst = exp_busy && rd_rvalid && (n_rcv == exp_len - 1);
        chk("busy",      int'(busy),      int'(exp_busy));
        chk("cmd_ready", int'(cmd_ready), int'(!exp_busy));
        chk("done",      int'(done),      int'(cyc == done_due));
        chk("rd_cen",    int'(rd_cen),    int'(exp_cen));
        chk("rd_wen",    int'(rd_wen),    0);
        if (exp_cen) chk("rd_addr", int'(rd_addr), int'(addr_at(n_iss)));
        chk("out_valid", int'(out_valid), int'(exp_busy && rd_rvalid));
        chk("rd_rready", int'(rd_rready), int'(exp_busy && out_ready));
        chk("out_last",  int'(out_last),  int'(exp_lst));
        if (exp_busy && rd_rvalid) chkd("out_data", out_data, mkdata(addr_at(n_rcv)));
        if (exp_busy) chk("outst", int'(dut.outst_q), n_iss - n_rcv);
        last_cen = rd_cen;

        if (rd_rvalid && rd_rready) begin
            assert (dut.outst_q != 0) else $error("response arrived with no read outstanding");
            if (pend_addr.size() > 0) begin
                void'(pend_addr.pop_front());
                void'(pend_rdy.pop_front());
            end
            resp_allow--;
            n_rcv++;
            if (n_rcv == exp_len) begin
                exp_busy = 1'b0;
                done_due = cyc + 1;
            end
        end
        if (rd_cen && rd_ready) begin
            pend_addr.push_back(rd_addr);
            pend_rdy.push_back(cyc + lat);
            if (n_iss == 0) begin
                first_iss_cyc = cyc;
                first_addr    = rd_addr;
            end
            last_iss_cyc = cyc;
            last_addr    = rd_addr;
            n_iss++;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (cmd_valid && cmd_ready) begin
            exp_base = cmd_base_addr;
            exp_len  = int'(cmd_len);
            n_iss    = 0;
            n_rcv    = 0;
            acc_cyc  = cyc;
            nxt_cv   = 1'b0;
            if (cmd_len == '0) done_due = cyc + 1;
            else               exp_busy = 1'b1;
        end
        cyc++;
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) step();
        chk("done_reached", done_cnt - start, 1);
    endtask

    task automatic issue_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l);
        nxt_cv   = 1'b1;
        nxt_base = b;
        nxt_len  = l;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_done"},      int'(done),      0);
        chk({tag, "_rd_cen"},    int'(rd_cen),    0);
        chk({tag, "_rd_wen"},    int'(rd_wen),    0);
        chk({tag, "_rd_rready"}, int'(rd_rready), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"},  int'(out_last),  0);
        chk({tag, "_rd_addr"},   int'(rd_addr),   0);
        chk({tag, "_iss_cnt"},   int'(dut.iss_cnt_q), 0);
        chk({tag, "_rcv_cnt"},   int'(dut.rcv_cnt_q), 0);
        chk({tag, "_outst"},     int'(dut.outst_q),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{15'h0010, 16'd4, 2, 0, 0, 15'h0010, 15'h0013, 4, 3};
        vecs[1] = '{15'h7FFE, 16'd4, 1, 0, 0, 15'h7FFE, 15'h0001, 4, 3};
        vecs[2] = '{15'h0100, 16'd8, 3, 1, 1, 15'h0100, 15'h0107, 8, -1};
        vecs[3] = '{15'h0000, 16'd1, 1, 0, 0, 15'h0000, 15'h0000, 1, 0};
        vecs[4] = '{15'h2222, 16'd6, 4, 0, 0, 15'h2222, 15'h2227, 6, -1};
        vecs[5] = '{15'h1234, 16'd5, 1, 1, 0, 15'h1234, 15'h1238, 5, -1};
        vecs[6] = '{15'h0050, 16'd8, 3, 0, 0, 15'h0050, 15'h0057, 8, 7};

        rst_n         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_base_addr = '0;
        cmd_len       = '0;
        rd_ready      = 1'b0;
        rd_rdata      = '0;
        rd_rvalid     = 1'b0;
        out_ready     = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // Table-driven commands.
        for (int v = 0; v < 7; v++) begin
            lat        = vecs[v].lat;
            omode      = vecs[v].omode;
            rmode      = vecs[v].rmode;
            resp_allow = 1 << 20;
            issue_cmd(vecs[v].base, vecs[v].len);
            wait_done(400);
            chk($sformatf("v%0d_beats", v), n_rcv, vecs[v].exp_beats);
            chk($sformatf("v%0d_first", v), int'(first_addr), int'(vecs[v].exp_first));
            chk($sformatf("v%0d_last", v),  int'(last_addr),  int'(vecs[v].exp_last));
            if (vecs[v].exp_span >= 0)
                chk($sformatf("v%0d_span", v), last_iss_cyc - first_iss_cyc, vecs[v].exp_span);
            step();
        end

        // Outstanding limit: responses held off, then released one at a time.
        lat = 1; omode = 0; rmode = 0; resp_allow = 0;
        issue_cmd(15'h0200, 16'd8);
        repeat (10) step();
        chk("outst_lim_iss", n_iss, 4);
        chk("outst_lim_cen", int'(last_cen), 0);
        resp_allow = 1;
        repeat (6) step();
        chk("outst_rel_iss", n_iss, 5);
        chk("outst_rel_rcv", n_rcv, 1);
        resp_allow = 1 << 20;
        wait_done(200);
        chk("outst_beats", n_rcv, 8);
        chk("outst_last", int'(last_addr), 'h207);
        step();

        // len=0 completes next cycle with no requests.
        begin
            int start;
            start = done_cnt;
            issue_cmd(15'h0300, 16'd0);
            step();
            step();
            chk("len0_done", done_cnt - start, 1);
            chk("len0_iss", n_iss, 0);
        end

        // Command presented while busy is only taken in the done cycle.
        issue_cmd(15'h0400, 16'd4);
        step();
        issue_cmd(15'h0500, 16'd2);
        wait_done(200);
        chk("busy_cmd_acc", acc_cyc, last_done_cyc);
        chk("busy_cmd_base", int'(exp_base), 'h500);
        wait_done(200);
        chk("busy_cmd_beats", n_rcv, 2);
        chk("busy_cmd_first", int'(first_addr), 'h500);
        step();

        // Reset after 3 of 8 requests issued.
        lat = 1; omode = 0; rmode = 0; resp_allow = 0;
        issue_cmd(15'h0600, 16'd8);
        for (int i = 0; i < 50 && n_iss < 3; i++) step();
        rmode = 2;
        step();
        chk("mid_iss", n_iss, 3);
        rd_rvalid = 1'b1;
        rd_rdata  = mkdata(15'h0600);
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        pend_addr.delete();
        pend_rdy.delete();
        exp_busy  = 1'b0;
        n_iss     = 0;
        n_rcv     = 0;
        done_due  = -1;
        rd_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rmode = 0; resp_allow = 1 << 20;
        issue_cmd(15'h0700, 16'd2);
        wait_done(100);
        chk("post_rst_beats", n_rcv, 2);
        chk("post_rst_first", int'(first_addr), 'h700);
        chk("post_rst_last", int'(last_addr), 'h701);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
